// File: rtl/disp_arb_scan.sv
// Six-digit display: round-robin write arbiter for two requesters plus a multiplexed scan driver.
// Optional inter-digit blanking is enabled by defining DISP_ARB_SCAN_BLANK_EN.
module disp_arb_scan #(
  parameter int unsigned DWELL = 16,
  parameter int unsigned BLANK = 2
) (
  input  logic       clk100khz,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       a_req,
  input  logic [2:0] a_idx,
  input  logic [7:0] a_seg,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [2:0] b_idx,
  input  logic [7:0] b_seg,
  output logic       b_ack,
  output logic [5:0] scan,
  output logic [7:0] dout
);

  if (DWELL < 1 || DWELL > 255) begin : gen_bad_dwell
    $error("DWELL must be in 1..255");
  end
  if (BLANK < 1 || BLANK > 255) begin : gen_bad_blank
    $error("BLANK must be in 1..255");
  end

  typedef enum logic [0:0] {StShow, StGap} state_e;

  localparam logic [7:0] DwellLast = 8'(DWELL - 1);
`ifdef DISP_ARB_SCAN_BLANK_EN
  localparam logic [7:0] BlankLast = 8'(BLANK - 1);
`endif

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d, ptr_next;
  logic [7:0] cnt_q, cnt_d;

  logic [7:0] d_q [6];
  logic [7:0] d_d [6];

  logic       a_ack_q, b_ack_q;
  logic       prio_b_q, prio_b_d;
  logic       a_elig, b_elig, a_gnt, b_gnt;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [7:0] wr_seg;

  logic [5:0] scan_q, scan_d;
  logic [7:0] dout_q, dout_d;

  // A channel whose ack is showing is still holding the request it was just granted.
  always_comb begin
    a_elig   = a_req & ~a_ack_q & ~clr;
    b_elig   = b_req & ~b_ack_q & ~clr;
    a_gnt    = a_elig & (~b_elig | ~prio_b_q);
    b_gnt    = b_elig & (~a_elig | prio_b_q);
    prio_b_d = prio_b_q;
    if (a_gnt) begin
      prio_b_d = 1'b1;
    end else if (b_gnt) begin
      prio_b_d = 1'b0;
    end
    wr_en  = a_gnt | b_gnt;
    wr_idx = a_gnt ? a_idx : b_idx;
    wr_seg = a_gnt ? a_seg : b_seg;
  end

  // Indices 6 and 7 match no register, so such writes are acked and dropped.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      d_d[i] = d_q[i];
      if (clr) begin
        d_d[i] = '0;
      end else if (wr_en && wr_idx == 3'(i)) begin
        d_d[i] = wr_seg;
      end
    end
  end

  always_comb begin
    ptr_next = (ptr_q == 3'd5) ? 3'd0 : ptr_q + 3'd1;
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q + 8'd1;
    unique case (state_q)
      StShow: begin
        if (cnt_q == DwellLast) begin
          cnt_d = '0;
`ifdef DISP_ARB_SCAN_BLANK_EN
          state_d = StGap;
`else
          ptr_d = ptr_next;
`endif
        end
      end
      StGap: begin
`ifdef DISP_ARB_SCAN_BLANK_EN
        if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          state_d = StShow;
          ptr_d   = ptr_next;
        end
`else
        cnt_d   = '0;
        state_d = StShow;
`endif
      end
      default: begin
        cnt_d   = '0;
        state_d = StShow;
      end
    endcase
  end

  always_comb begin
    scan_d = '0;
    dout_d = '0;
    if (state_q == StShow) begin
      for (int i = 0; i < 6; i++) begin
        if (ptr_q == 3'(i)) begin
          scan_d[i] = 1'b1;
          dout_d    = d_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk100khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StShow;
      ptr_q    <= '0;
      cnt_q    <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      prio_b_q <= 1'b0;
      scan_q   <= '0;
      dout_q   <= '0;
      for (int i = 0; i < 6; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      a_ack_q  <= a_gnt;
      b_ack_q  <= b_gnt;
      prio_b_q <= prio_b_d;
      scan_q   <= scan_d;
      dout_q   <= dout_d;
      for (int i = 0; i < 6; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign a_ack = a_ack_q;
  assign b_ack = b_ack_q;
  assign scan  = scan_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_disp_arb_scan.sv
// Bench for disp_arb_scan: directed scenarios plus random traffic checked against a
// cycle-count based reference model of the scan and the arbitration rules.
module tb_disp_arb_scan;

`ifdef DISP_ARB_SCAN_BLANK_EN
  localparam bit          BlankEn = 1'b1;
  localparam int unsigned Dwell   = 4;
`else
  localparam bit          BlankEn = 1'b0;
  localparam int unsigned Dwell   = 3;
`endif
  localparam int unsigned Blank = 2;

  logic       clk100khz = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [2:0] a_idx = '0, b_idx = '0;
  logic [7:0] a_seg = '0, b_seg = '0;
  logic       a_ack, b_ack;
  logic [5:0] scan;
  logic [7:0] dout;

  disp_arb_scan #(.DWELL(Dwell), .BLANK(Blank)) dut (
    .clk100khz(clk100khz),
    .rst_n    (rst_n),
    .clr      (clr),
    .a_req    (a_req),
    .a_idx    (a_idx),
    .a_seg    (a_seg),
    .a_ack    (a_ack),
    .b_req    (b_req),
    .b_idx    (b_idx),
    .b_seg    (b_seg),
    .b_ack    (b_ack),
    .scan     (scan),
    .dout     (dout)
  );

  always #5 clk100khz = ~clk100khz;

  int          ncmp = 0;
  int          nfail = 0;
  int unsigned n;          // rising edges since reset release
  logic [7:0]  md [6];
  logic        m_prio_b, m_aack, m_back;
  logic [5:0]  e_scan;
  logic [7:0]  e_dout;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n        = 0;
    m_prio_b = 1'b0;
    m_aack   = 1'b0;
    m_back   = 1'b0;
    for (int i = 0; i < 6; i++) md[i] = '0;
  endtask

  // Predict one clock edge from the current inputs, apply it, then compare.
  task automatic cycle(input string tag);
    int unsigned per, s, dig;
    bit          show, ea, eb, ga, gb;
    per    = Dwell + (BlankEn ? Blank : 0);
    s      = n % (6 * per);
    dig    = s / per;
    show   = (s % per) < Dwell;
    e_scan = show ? 6'(1 << dig) : 6'd0;
    e_dout = show ? md[dig] : 8'd0;
    ga = 1'b0;
    gb = 1'b0;
    if (!clr) begin
      ea = a_req && !m_aack;
      eb = b_req && !m_back;
      if (ea && eb) begin
        ga = !m_prio_b;
        gb = m_prio_b;
      end else begin
        ga = ea;
        gb = eb;
      end
    end
    if (clr) begin
      for (int i = 0; i < 6; i++) md[i] = '0;
    end else if (ga && a_idx < 3'd6) begin
      md[int'(a_idx)] = a_seg;
    end else if (gb && b_idx < 3'd6) begin
      md[int'(b_idx)] = b_seg;
    end
    if (ga) m_prio_b = 1'b1;
    if (gb) m_prio_b = 1'b0;
    m_aack = ga;
    m_back = gb;
    n++;
    @(posedge clk100khz);
    #1;
    chk({tag, ".scan"}, {2'b00, scan}, {2'b00, e_scan});
    chk({tag, ".dout"}, dout, e_dout);
    chk({tag, ".a_ack"}, {7'd0, a_ack}, {7'd0, m_aack});
    chk({tag, ".b_ack"}, {7'd0, b_ack}, {7'd0, m_back});
  endtask

  task automatic idle();
    a_req = 1'b0;
    b_req = 1'b0;
    clr   = 1'b0;
  endtask

  initial begin
    bit found;
    // Reset held with the clock running.
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk100khz);
    #1;
    chk("rst.scan", {2'b00, scan}, 8'd0);
    chk("rst.dout", dout, 8'd0);
    chk("rst.a_ack", {7'd0, a_ack}, 8'd0);
    chk("rst.b_ack", {7'd0, b_ack}, 8'd0);
    @(negedge clk100khz);
    rst_n = 1'b1;

    // First edge shows digit 0, then two full idle scan periods.
    cycle("first");
    chk("first.scan1", {2'b00, scan}, 8'h01);
    repeat (2 * 6 * (Dwell + (BlankEn ? Blank : 0))) cycle("idle_scan");

    // Round-robin tie with both requests held.
    a_req = 1'b1; a_idx = 3'd0; a_seg = 8'h06;
    b_req = 1'b1; b_idx = 3'd1; b_seg = 8'h5B;
    cycle("tie1");
    chk("tie.a_first", {7'd0, a_ack}, 8'd1);
    cycle("tie2");
    chk("tie.b_second", {7'd0, b_ack}, 8'd1);
    repeat (4) cycle("tie");
    idle();
    repeat (40) cycle("tie_scan");

    // Clear wins over a simultaneous write; the request then goes through.
    clr = 1'b1;
    a_req = 1'b1; a_idx = 3'd2; a_seg = 8'h4F;
    cycle("clr");
    chk("clr.no_ack", {7'd0, a_ack}, 8'd0);
    clr = 1'b0;
    cycle("clr_next");
    chk("clr.a_ack", {7'd0, a_ack}, 8'd1);
    idle();
    repeat (40) cycle("clr_scan");

    // Out-of-range index is acked once and discarded.
    b_req = 1'b1; b_idx = 3'd7; b_seg = 8'hFF;
    cycle("oor");
    chk("oor.b_ack", {7'd0, b_ack}, 8'd1);
    idle();
    cycle("oor_drop");
    chk("oor.single", {7'd0, b_ack}, 8'd0);
    repeat (40) cycle("oor_scan");

    // Random traffic; each requester holds until it sees its ack.
    for (int k = 0; k < 600; k++) begin
      if (!a_req || m_aack) begin
        a_req = ($urandom_range(0, 2) != 0);
        a_idx = 3'($urandom_range(0, 7));
        a_seg = 8'($urandom);
      end
      if (!b_req || m_back) begin
        b_req = ($urandom_range(0, 2) != 0);
        b_idx = 3'($urandom_range(0, 7));
        b_seg = 8'($urandom);
      end
      clr = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end
    idle();

    // Asynchronous reset while digit 2 is shown and a write is pending.
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      cycle("seek");
      found = (e_scan == 6'b000100);
    end
    chk("seek.found", {7'd0, found}, 8'd1);
    a_req = 1'b1; a_idx = 3'd3; a_seg = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.scan", {2'b00, scan}, 8'd0);
    chk("arst.dout", dout, 8'd0);
    chk("arst.a_ack", {7'd0, a_ack}, 8'd0);
    chk("arst.b_ack", {7'd0, b_ack}, 8'd0);
    model_reset();
    repeat (2) @(negedge clk100khz);
    chk("arst.hold", {2'b00, scan}, 8'd0);
    rst_n = 1'b1;
    cycle("post_rst");
    chk("post_rst.scan1", {2'b00, scan}, 8'h01);
    chk("post_rst.dout0", dout, 8'd0);
    idle();
    repeat (40) cycle("post_scan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/disp_arb_scan.md
DISP_ARB_SCAN -- requirements
Module: disp_arb_scan

Interface
REQ-001 The block SHALL have parameter DWELL, default 16, giving the cycles each digit is driven (legal 1..255).
REQ-002 The block SHALL have parameter BLANK, default 2, giving the blanking cycles between digits (legal 1..255).
REQ-003 The block SHALL have port clk100khz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of all six digit registers.
REQ-006 The block SHALL have ports a_req (input, 1), a_idx (input, 3), a_seg (input, 8) and a_ack (output, 1): requester A write channel.
REQ-007 The block SHALL have ports b_req (input, 1), b_idx (input, 3), b_seg (input, 8) and b_ack (output, 1): requester B write channel.
REQ-008 The block SHALL have port scan, output, 6 bits: one-hot digit select, bit0 = digit 0.
REQ-009 The block SHALL have port dout, output, 8 bits: segment pattern for the selected digit.

Function
REQ-010 The block SHALL hold six 8-bit digit registers, d0..d5.
REQ-011 Arbitration SHALL be round-robin: with one request pending, that requester is granted; with both pending, the requester not granted last is granted; the first tie after reset goes to A.
REQ-012 A grant SHALL write the granted channel's seg into d[idx] at that clock edge, and the matching ack SHALL be high for exactly the next cycle.
REQ-013 Each requester SHALL hold req, idx and seg stable until it samples ack high; the arbiter SHALL NOT grant a channel in a cycle where that channel's ack is high, so a held req is never written twice.
REQ-014 An idx of 6 or 7 SHALL be granted and acked, and the write SHALL be discarded.
REQ-015 At most one write SHALL occur per cycle.
REQ-016 clr high SHALL zero d0..d5 at that edge and SHALL take priority over any write; no grant or ack SHALL occur for that cycle, and requests stay pending.
REQ-017 The scan FSM SHALL have two states: SHOW and GAP, with a digit pointer ptr (0..5) and an 8-bit cycle counter.
REQ-018 In SHOW, the FSM SHALL stay for DWELL cycles, then go to GAP with the counter cleared.
REQ-019 In GAP, the FSM SHALL stay for BLANK cycles, then return to SHOW with ptr incremented; ptr wraps from 5 to 0.
REQ-020 scan and dout SHALL be registered, with a one-cycle latency from FSM state and digit registers.
REQ-021 In SHOW, scan SHALL equal one-hot(ptr) and dout SHALL equal d[ptr]; in GAP, scan and dout SHALL both be 0.
REQ-022 A write to the digit currently shown SHALL appear on dout in the cycle after the write edge.
REQ-023 clr and writes SHALL NOT disturb the FSM state, ptr or the counter.

Reset
REQ-024 While rst_n is low, regardless of the clock, the block SHALL hold scan=0, dout=0, a_ack=0, b_ack=0, d0..d5=0, state=SHOW, ptr=0, counter=0 and round-robin priority = A.
REQ-025 On reset deassertion, the first rising edge SHALL produce scan=000001 and dout=d0.
REQ-026 Reset asserted mid-dwell or mid-write SHALL abort immediately with no partial write retained.

Configuration
REQ-027 With macro DISP_ARB_SCAN_BLANK_EN defined, the GAP state SHALL be implemented as in REQ-019 and REQ-021.
REQ-028 Without DISP_ARB_SCAN_BLANK_EN, GAP SHALL be omitted: SHOW advances ptr directly after DWELL cycles, scan is never all-zero after reset, and BLANK is ignored.

Verification
REQ-029 Scan timing: DWELL=4, BLANK=2, macro defined, no writes -> scan sequence 000001 x4, 000000 x2, 000010 x4, ... and wrap back to 000001 after 000000 following digit 5; period 36 cycles.
REQ-030 Round-robin tie: a_req and b_req held continuously with idx 0 and 1, seg 8'h06 and 8'h5B -> A acked first, then B, alternating; d0=8'h06, d1=8'h5B; no double writes.
REQ-031 Clear priority: clr=1 in the same cycle as a_req (idx 2, seg 8'h4F) -> no ack that cycle, d0..d5=0; then the next cycle A is acked and d2=8'h4F.
REQ-032 Out-of-range index: b_idx=7, seg 8'hFF -> b_ack pulses once and d0..d5 are unchanged.
REQ-033 Reset mid-operation: rst_n pulled low while scan=000100 and a write is pending -> scan=0, dout=0, acks=0 asynchronously; after release, scan=000001 and dout=0.
REQ-034 Macro undefined: DWELL=3 -> scan 000001 x3, then 000010 x3 with no zero cycles; live update of d[ptr] visible on dout one cycle after the write.
